// File: rtl/shake_arbiter.sv
// Round-robin arbiter sharing one SHAKE core between N requesters; the grant is held
// for a whole transaction (header, absorb words, squeeze words back to the owner).
module shake_arbiter #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid_in,
   input  logic [N*W-1:0] req_data_in,
   output logic [N-1:0]   req_ready_out,
   output logic [N-1:0]   req_valid_out,
   output logic [W-1:0]   req_data_out,
   input  logic [N-1:0]   req_ready_in,
   output logic           core_valid_in,
   output logic [W-1:0]   core_data_in,
   input  logic           core_ready_out,
   input  logic           core_valid_out,
   input  logic [W-1:0]   core_data_out,
   output logic           core_ready_in,
   output logic [N-1:0]   grant,
   output logic           busy
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StHeader, StAbsorb, StSqueeze} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [IdxW-1:0]   rr_q, rr_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [30:0]       in_cnt_q, in_cnt_d;
   logic [32:0]       out_cnt_q, out_cnt_d;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic [W-1:0]      owner_data;
   logic [30:0]       hdr_in_words;
   logic [32:0]       hdr_out_words;
   logic              in_xfer;
   logic              out_xfer;
   logic              release_txn;
   int unsigned       scan;

   // First requesting index at or above the rr pointer, wrapping modulo N.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan       = 0;
      for (int k = 0; k < N; k++) begin
         scan = 32'(rr_q) + 32'(k);
         if (scan >= N) scan = scan - N;
         if (!pick_found && req_valid_in[IdxW'(scan)]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(scan);
         end
      end
   end

   assign owner_data    = req_data_in[32'(owner_q)*W +: W];
   assign hdr_in_words  = ({1'b0, owner_data[61:32]} + 31'd7) >> 3;
   assign hdr_out_words = ({1'b0, owner_data[31:0]} + 33'd7) >> 3;

   always_comb begin
      req_ready_out = '0;
      req_valid_out = '0;
      req_data_out  = core_data_out;
      core_valid_in = 1'b0;
      core_data_in  = '0;
      core_ready_in = 1'b0;
      unique case (state_q)
         StHeader, StAbsorb: begin
            core_valid_in          = req_valid_in[owner_q];
            core_data_in           = owner_data;
            req_ready_out[owner_q] = core_ready_out;
         end
         StSqueeze: begin
            req_valid_out[owner_q] = core_valid_out;
            core_ready_in          = req_ready_in[owner_q];
         end
         default: ;
      endcase
   end

   assign in_xfer  = core_valid_in & core_ready_out;
   assign out_xfer = core_valid_out & core_ready_in;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      release_txn = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               owner_d = pick_idx;
               grant_d = N'(1) << pick_idx;
               busy_d  = 1'b1;
               state_d = StHeader;
            end
         end
         StHeader: begin
            if (in_xfer) begin
               in_cnt_d  = hdr_in_words;
               out_cnt_d = hdr_out_words;
               if (hdr_in_words != '0)       state_d = StAbsorb;
               else if (hdr_out_words != '0) state_d = StSqueeze;
               else                          release_txn = 1'b1;
            end
         end
         StAbsorb: begin
            if (in_xfer) begin
               in_cnt_d = in_cnt_q - 31'd1;
               if (in_cnt_q == 31'd1) begin
                  if (out_cnt_q != '0) state_d = StSqueeze;
                  else                 release_txn = 1'b1;
               end
            end
         end
         StSqueeze: begin
            if (out_xfer) begin
               out_cnt_d = out_cnt_q - 33'd1;
               if (out_cnt_q == 33'd1) release_txn = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (release_txn) begin
         state_d = StIdle;
         grant_d = '0;
         busy_d  = 1'b0;
         rr_d    = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + IdxW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         rr_q      <= '0;
         owner_q   <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_shake_arbiter.sv
// Directed bench for shake_arbiter: three requester models, a counting core model and
// hand-computed expectations for word counts, ordering and grant behaviour.
module tb_shake_arbiter;

   localparam logic [63:0] SqBase = 64'hC0DE_0000_0000_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   req_valid_in, req_ready_out, req_valid_out, req_ready_in, grant;
   logic [191:0] req_data_in;
   logic [63:0]  req_data_out, core_data_in, core_data_out;
   logic         core_valid_in, core_ready_out, core_valid_out, core_ready_in, busy;

   shake_arbiter #(.N(3), .W(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_in   (req_valid_in),
      .req_data_in    (req_data_in),
      .req_ready_out  (req_ready_out),
      .req_valid_out  (req_valid_out),
      .req_data_out   (req_data_out),
      .req_ready_in   (req_ready_in),
      .core_valid_in  (core_valid_in),
      .core_data_in   (core_data_in),
      .core_ready_out (core_ready_out),
      .core_valid_out (core_valid_out),
      .core_data_out  (core_data_out),
      .core_ready_in  (core_ready_in),
      .grant          (grant),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [63:0] txm [3][32];
   int          txh [3];
   int          txt [3];
   bit          stall [3];
   logic [63:0] rxm [3][32];
   int          rxn [3];
   logic [63:0] clog [64];
   int          cn;
   logic [63:0] sq_ctr;
   bit          sq_en, rnd;
   logic [2:0]  glog [8];
   int          gn;
   logic [2:0]  prev_g;
   int          viol;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] hdr(input int unsigned inb, input int unsigned outb);
      logic [31:0] i32, o32;
      i32 = inb;
      o32 = outb;
      return {2'b01, i32[29:0], o32};
   endfunction

   function automatic bit coin();
      return rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
   endfunction

   task automatic push(input int i, input logic [63:0] w);
      txm[i][txt[i]] = w;
      txt[i]++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 3; i++) begin
         req_valid_in[i] = (txh[i] < txt[i]) && !stall[i];
         req_data_in[i*64 +: 64] = (txh[i] < txt[i]) ? txm[i][txh[i]] : 64'h0;
         req_ready_in[i] = coin();
      end
      core_ready_out = coin();
      core_valid_out = sq_en && coin();
      core_data_out  = sq_ctr;
   endtask

   // Record every transfer visible before the coming edge, then advance one cycle.
   task automatic cycle();
      if (core_valid_in && core_ready_out) begin
         if (cn < 64) clog[cn] = core_data_in;
         cn++;
      end
      for (int i = 0; i < 3; i++) begin
         if (req_valid_in[i] && req_ready_out[i]) txh[i]++;
         if (req_valid_out[i] && req_ready_in[i]) begin
            if (rxn[i] < 32) rxm[i][rxn[i]] = req_data_out;
            rxn[i]++;
         end
         if (!grant[i] && (req_ready_out[i] || req_valid_out[i])) viol++;
      end
      if (core_valid_out && core_ready_in) sq_ctr++;
      if (grant != 3'b000 && grant != prev_g && gn < 8) begin
         glog[gn] = grant;
         gn++;
      end
      prev_g = grant;
      @(posedge clk);
      @(negedge clk);
      drive_inputs();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         txh[i] = 0; txt[i] = 0; rxn[i] = 0; stall[i] = 1'b0;
      end
      cn = 0; gn = 0; prev_g = 3'b000;
      sq_ctr = SqBase; sq_en = 1'b1; rnd = 1'b0;
      drive_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive_inputs();
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, bad;
      viol = 0;

      // Reset state with core offering squeeze data and requesters ready.
      do_reset();
      check_eq("rst_grant", grant, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req_ready_out", req_ready_out, 0);
      check_eq("rst_req_valid_out", req_valid_out, 0);
      check_eq("rst_core_valid_in", core_valid_in, 0);
      check_eq("rst_core_ready_in", core_ready_in, 0);

      // Single requester 1: 16 in bytes, 32 out bytes.
      push(1, hdr(16, 32)); push(1, 64'hAAAA_0001); push(1, 64'hAAAA_0002);
      drive_inputs(); #1;
      check_eq("t1_idle_no_fwd", core_valid_in, 0);
      cycle();
      check_eq("t1_grant", grant, 3'b010);
      check_eq("t1_busy", busy, 1);
      t = 0;
      while (rxn[1] < 4 && t < 200) begin cycle(); t++; end
      check_eq("t1_rx_count", rxn[1], 4);
      check_eq("t1_rel_grant", grant, 0);
      check_eq("t1_rel_busy", busy, 0);
      check_eq("t1_core_words", cn, 3);
      check_eq("t1_hdr", clog[0], hdr(16, 32));
      check_eq("t1_w1", clog[1], 64'hAAAA_0001);
      check_eq("t1_w2", clog[2], 64'hAAAA_0002);
      for (int k = 0; k < 4; k++) check_eq("t1_rx", rxm[1][k], SqBase + 64'(k));
      repeat (5) cycle();
      check_eq("t1_sq_consumed", sq_ctr - SqBase, 4);

      // All three at once from reset: order 0,1,2 with no interleaving.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         push(i, hdr(8, 8));
         push(i, 64'hD000 + 64'(i));
      end
      drive_inputs(); #1;
      t = 0;
      while ((rxn[0] < 1 || rxn[1] < 1 || rxn[2] < 1) && t < 300) begin cycle(); t++; end
      check_eq("t2_grants", gn, 3);
      check_eq("t2_g0", glog[0], 3'b001);
      check_eq("t2_g1", glog[1], 3'b010);
      check_eq("t2_g2", glog[2], 3'b100);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (clog[2*i] !== hdr(8, 8)) bad++;
         if (clog[2*i+1] !== 64'hD000 + 64'(i)) bad++;
         if (rxm[i][0] !== SqBase + 64'(i)) bad++;
      end
      check_eq("t2_order", bad, 0);
      check_eq("t2_core_words", cn, 6);

      // Header-only transaction, then in_len=9 needing two absorb words.
      do_reset();
      push(2, hdr(0, 0));
      drive_inputs(); #1;
      t = 0;
      while (txh[2] < txt[2] && t < 50) begin cycle(); t++; end
      check_eq("t3_hdr_only_words", cn, 1);
      check_eq("t3_hdr_only_busy", busy, 0);
      check_eq("t3_hdr_only_grant", grant, 0);
      push(2, hdr(9, 0)); push(2, 64'hB001); push(2, 64'hB002);
      drive_inputs(); #1;
      t = 0;
      while (txh[2] < txt[2] && t < 50) begin cycle(); t++; end
      check_eq("t3_in9_words", cn, 4);
      check_eq("t3_in9_busy", busy, 0);
      check_eq("t3_no_squeeze", sq_ctr - SqBase, 0);

      // Random backpressure: 40 bytes in (5 words), 168 bytes out (21 words).
      do_reset();
      rnd = 1'b1;
      push(0, hdr(40, 168));
      for (int k = 0; k < 5; k++) push(0, 64'hE000 + 64'(k));
      drive_inputs(); #1;
      t = 0;
      while (rxn[0] < 21 && t < 3000) begin cycle(); t++; end
      repeat (20) cycle();
      check_eq("t4_core_words", cn, 6);
      check_eq("t4_rx_count", rxn[0], 21);
      check_eq("t4_sq_consumed", sq_ctr - SqBase, 21);
      bad = 0;
      if (clog[0] !== hdr(40, 168)) bad++;
      for (int k = 0; k < 5; k++) if (clog[k+1] !== 64'hE000 + 64'(k)) bad++;
      for (int k = 0; k < 21; k++) if (rxm[0][k] !== SqBase + 64'(k)) bad++;
      check_eq("t4_data_order", bad, 0);
      rnd = 1'b0;

      // Reset during squeeze with 3 of 5 words outstanding.
      do_reset();
      push(1, hdr(0, 40));
      drive_inputs(); #1;
      t = 0;
      while (rxn[1] < 2 && t < 100) begin cycle(); t++; end
      check_eq("t5_mid_busy", busy, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_eq("t5_grant", grant, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_req_valid_out", req_valid_out, 0);
      check_eq("t5_req_ready_out", req_ready_out, 0);
      check_eq("t5_core_valid_in", core_valid_in, 0);
      check_eq("t5_core_ready_in", core_ready_in, 0);
      push(0, hdr(0, 8)); push(2, hdr(0, 8));
      drive_inputs(); #1;
      cycle();
      check_eq("t5_regrant", grant, 3'b001);

      // Owner stalls for 4 cycles mid-absorb.
      do_reset();
      push(0, hdr(32, 8));
      for (int k = 0; k < 4; k++) push(0, 64'hF000 + 64'(k));
      drive_inputs(); #1;
      t = 0;
      while (cn < 3 && t < 100) begin cycle(); t++; end
      stall[0] = 1'b1;
      drive_inputs(); #1;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         if (core_valid_in !== 1'b0 || grant !== 3'b001) bad++;
         cycle();
      end
      check_eq("t6_stall", bad, 0);
      check_eq("t6_stall_words", cn, 3);
      stall[0] = 1'b0;
      drive_inputs(); #1;
      t = 0;
      while (rxn[0] < 1 && t < 100) begin cycle(); t++; end
      check_eq("t6_core_words", cn, 5);
      bad = 0;
      for (int k = 0; k < 4; k++) if (clog[k+1] !== 64'hF000 + 64'(k)) bad++;
      check_eq("t6_data", bad, 0);
      check_eq("t6_rx", rxm[0][0], SqBase);
      check_eq("t6_rel_grant", grant, 0);

      check_eq("non_owner_ready_valid", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shake_arbiter.md
Name: shake_arbiter

Overview:
- Shares one SHAKE core (load stage input stream, squeeze output stream) between N requesters, e.g. the matrix expander, the mask sampler and the hash units in the Dilithium top level.
- Grants the core round-robin and holds the grant for one whole transaction: header word, absorb words, then every squeeze word returned to the owner.
- Parses the header only to count words. The header is also forwarded unchanged to the core, which does its own padding and control-register loading.

Parameters:
N, 3, number of requesters (2..8)
W, 64, word width; equals keccak_pkg_mine::w

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid_in  in  N  requester i drives a valid input word
req_data_in  in  N*W  requester i input word at bits [i*W +: W]
req_ready_out  out  N  arbiter accepts requester i input word
req_valid_out  out  N  squeeze word valid for requester i
req_data_out  out  W  shared squeeze data, meaningful where req_valid_out set
req_ready_in  in  N  requester i accepts squeeze word
core_valid_in  out  1  word valid to core load stage
core_data_in  out  W  word to core load stage
core_ready_out  in  1  load stage ready
core_valid_out  in  1  core squeeze word valid
core_data_out  in  W  core squeeze word
core_ready_in  out  1  arbiter accepts squeeze word
grant  out  N  one-hot current owner, 0 when idle
busy  out  1  transaction in progress

Behaviour:
- Header word, as the first word of every transaction: [63:62] operation_mode, [61:32] input length in bytes, [31:0] output length in bytes.
  - in_words = (in_len+7)>>3, computed on 31 bits.
  - out_words = (out_len+7)>>3, computed on 33 bits, so no overflow at 0xFFFFFFFF.
- Reset: state IDLE, grant=0, busy=0, rr pointer=0, counters=0. All req_ready_out, req_valid_out, core_valid_in and core_ready_in are 0.
- rst mid-transaction aborts immediately and no words are forwarded afterwards. The core shares rst and restarts with it.
- FSM states: IDLE, HEADER, ABSORB, SQUEEZE.
- IDLE:
  - If any req_valid_in is set, pick the first set bit searching upward from the rr pointer, wrapping modulo N.
  - Register the choice in grant, set busy, go to HEADER.
  - Grant decision takes 1 cycle. Nothing is forwarded in IDLE.
- Forwarding (HEADER and ABSORB), purely combinational:
  - core_valid_in = req_valid_in[g]
  - core_data_in = owner data
  - req_ready_out[g] = core_ready_out
  - All other req_ready_out = 0.
- HEADER: on a transfer (valid and ready), latch in_words and out_words.
  - in_words>0: go to ABSORB.
  - in_words=0 and out_words>0: go to SQUEEZE.
  - Both 0: go to IDLE (release).
- ABSORB: decrement the input counter per transfer. On the last transfer, go to SQUEEZE, or to IDLE if out_words=0.
- SQUEEZE, combinational:
  - req_valid_out[g] = core_valid_out
  - req_data_out = core_data_out
  - core_ready_in = req_ready_in[g]
  - Decrement the output counter per transfer; on the last transfer go to IDLE.
- Release, on the cycle of the final transfer:
  - Registered: grant=0 and busy=0 next cycle.
  - rr pointer = (g+1) mod N.
  - Minimum 1 IDLE cycle between transactions.
- Non-owners never see ready or valid asserted. The requests of non-owners are held, not dropped.
- core_ready_in=0 outside SQUEEZE.
- core squeeze words beyond out_words are not consumed; excess is the core's concern.
- A requester deasserting valid mid-transaction stalls the transaction and does not release the grant.

Test Plan:
- Single requester 1: header in_len=16 and out_len=32 bytes, then 2 words -> 3 core_valid_in transfers, then 4 words delivered on req_valid_out[1], then grant=0 and busy=0 the following cycle.
- All 3 requesters valid at once from reset -> grants in order 0,1,2, each holding its grant until its last squeeze word, with no interleaving.
- Header in_len=0, out_len=0 -> exactly 1 transfer, then immediate release. in_len=9 -> 2 absorb words (ceil).
- Random core_ready_out and req_ready_in backpressure with in_len=40, out_len=168 -> 5 absorb and 21 squeeze words, data order intact, no duplicates or loss.
- rst asserted during SQUEEZE with 3 words remaining -> next cycle grant=0, busy=0, all ready/valid outputs 0. A new request is then granted to requester 0.
- Owner drops req_valid_in for 4 cycles mid-ABSORB -> core_valid_in=0 for those cycles, grant unchanged, and the transaction completes normally.
